// File: rtl/mfp_seg7_serial_ctrl.sv
// -----------------------------------------------------------------------------
// mfp_seg7_serial_ctrl
//   Serialises eight hex digits into a 64-bit active-low segment frame and
//   shifts it out to an external display shift register. A new frame is sent
//   whenever the {DIGITS,DIGIT_EN} snapshot changes, after every reset, or on
//   a FORCE request while idle.
//
// Ports
//   HCLK      in   clock, rising edge
//   HRESETn   in   asynchronous active-low reset
//   DIGITS    in   eight hex digits, digit i = DIGITS[4i+3:4i]
//   DIGIT_EN  in   per-digit lit enable (0 -> byte FF, blank)
//   FORCE     in   single-cycle retransmit request (ignored while BUSY)
//   SEG_CLK   out  shift clock, DIV HCLK cycles per half-period
//   SEG_DT    out  serial data, MSB-first, stable while SEG_CLK is high
//   SEG_PEN   out  latch strobe, DIV cycles after the last bit
//   SEG_CLR_N out  active-low clear, released one edge after reset
//   BUSY      out  frame in progress (LOAD, SHIFT, LATCH)
// -----------------------------------------------------------------------------
module mfp_seg7_serial_ctrl #(
  parameter int unsigned DIV = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] DIGITS,
  input  logic [7:0]  DIGIT_EN,
  input  logic        FORCE,
  output logic        SEG_CLK,
  output logic        SEG_DT,
  output logic        SEG_PEN,
  output logic        SEG_CLR_N,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  state_t      r_state;
  logic [31:0] r_snap_dig;
  logic [7:0]  r_snap_en;
  logic        r_sent;
  logic [63:0] r_shift;
  logic [5:0]  r_bit;
  logic [7:0]  r_div;
  logic        r_clk;
  logic        r_dt;
  logic        r_pen;
  logic        r_clr_n;
  logic        r_busy;

  logic [63:0] w_frame;
  logic        w_trigger;
  logic        w_div_done;

  function automatic logic [7:0] f_hex2seg(input logic [3:0] i_hex);
    logic [7:0] v;
    case (i_hex)
      4'h0: v = 8'hC0;
      4'h1: v = 8'hF9;
      4'h2: v = 8'hA4;
      4'h3: v = 8'hB0;
      4'h4: v = 8'h99;
      4'h5: v = 8'h92;
      4'h6: v = 8'h82;
      4'h7: v = 8'hF8;
      4'h8: v = 8'h80;
      4'h9: v = 8'h90;
      4'hA: v = 8'h88;
      4'hB: v = 8'h83;
      4'hC: v = 8'hC6;
      4'hD: v = 8'hA1;
      4'hE: v = 8'h86;
      default: v = 8'h8E;
    endcase
    return v;
  endfunction

  // Byte for digit i sits at [8i+7:8i], so digit 7 leaves first when
  // shifting from bit 63 downwards.
  always_comb begin
    w_frame = '1;
    for (int unsigned i = 0; i < 8; i++) begin
      w_frame[8*i +: 8] = r_snap_en[i] ? f_hex2seg(r_snap_dig[4*i +: 4]) : 8'hFF;
    end
  end

  assign w_trigger  = !r_sent || FORCE || ({DIGITS, DIGIT_EN} != {r_snap_dig, r_snap_en});
  assign w_div_done = (r_div == DIV_LAST);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= ST_IDLE;
      r_snap_dig <= '0;
      r_snap_en  <= '0;
      r_sent     <= 1'b0;
      r_shift    <= '0;
      r_bit      <= '0;
      r_div      <= '0;
      r_clk      <= 1'b0;
      r_dt       <= 1'b0;
      r_pen      <= 1'b0;
      r_clr_n    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_clr_n <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          r_div <= '0;
          if (w_trigger) begin
            r_snap_dig <= DIGITS;
            r_snap_en  <= DIGIT_EN;
            r_sent     <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_shift <= w_frame;
          r_dt    <= w_frame[63];
          r_bit   <= '0;
          r_div   <= '0;
          r_clk   <= 1'b0;
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (!w_div_done) begin
            r_div <= r_div + 8'd1;
          end else begin
            r_div <= '0;
            if (!r_clk) begin
              r_clk <= 1'b1;
            end else if (r_bit == 6'd63) begin
              r_clk   <= 1'b0;
              r_dt    <= 1'b0;
              r_pen   <= 1'b1;
              r_state <= ST_LATCH;
            end else begin
              // Next data bit is presented on the same edge SEG_CLK falls.
              r_clk   <= 1'b0;
              r_bit   <= r_bit + 6'd1;
              r_shift <= {r_shift[62:0], 1'b0};
              r_dt    <= r_shift[62];
            end
          end
        end
        ST_LATCH: begin
          if (!w_div_done) begin
            r_div <= r_div + 8'd1;
          end else begin
            r_div   <= '0;
            r_pen   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign SEG_CLK   = r_clk;
  assign SEG_DT    = r_dt;
  assign SEG_PEN   = r_pen;
  assign SEG_CLR_N = r_clr_n;
  assign BUSY      = r_busy;

endmodule

// File: tb/tb_mfp_seg7_serial_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mfp_seg7_serial_ctrl
//   Two instances (DIV=1 and DIV=3) share stimulus. A passive monitor rebuilds
//   each transmitted frame from SEG_CLK/SEG_DT and records its timing; tests
//   compare those records against frames computed from the digit table.
// -----------------------------------------------------------------------------
module tb_mfp_seg7_serial_ctrl;

  typedef struct {
    logic [63:0] data;
    int unsigned bits;
    int unsigned blen;
    int unsigned plen;
    int unsigned ppulses;
    int unsigned start;
    int unsigned fin;
  } fr_t;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [31:0] DIGITS = '0;
  logic [7:0]  DIGIT_EN = 8'hFF;
  logic        FORCE = 1'b0;
  logic [1:0]  seg_clk, seg_dt, seg_pen, clr_n, busy;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  int unsigned viol [2] = '{0, 0};
  fr_t cur [2];
  fr_t q0 [$];
  fr_t q1 [$];
  logic [1:0] prev_clk = '0, prev_dt = '0, prev_busy = '0, prev_pen = '0;
  int unsigned hrun [2] = '{0, 0};
  logic [31:0] cur_d = '0;
  logic [7:0]  cur_en = 8'hFF;

  always #5 HCLK = ~HCLK;

  mfp_seg7_serial_ctrl #(.DIV(1)) u_dut_div1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .DIGITS(DIGITS), .DIGIT_EN(DIGIT_EN),
    .FORCE(FORCE), .SEG_CLK(seg_clk[0]), .SEG_DT(seg_dt[0]), .SEG_PEN(seg_pen[0]),
    .SEG_CLR_N(clr_n[0]), .BUSY(busy[0]));

  mfp_seg7_serial_ctrl #(.DIV(3)) u_dut_div3 (
    .HCLK(HCLK), .HRESETn(HRESETn), .DIGITS(DIGITS), .DIGIT_EN(DIGIT_EN),
    .FORCE(FORCE), .SEG_CLK(seg_clk[1]), .SEG_DT(seg_dt[1]), .SEG_PEN(seg_pen[1]),
    .SEG_CLR_N(clr_n[1]), .BUSY(busy[1]));

  function automatic int unsigned div_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [63:0] exp_frame(input logic [31:0] d, input logic [7:0] en);
    logic [7:0]  tbl [16];
    logic [63:0] f;
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    f = '0;
    for (int i = 7; i >= 0; i--) f = {f[55:0], en[i] ? tbl[d[4*i +: 4]] : 8'hFF};
    return f;
  endfunction

  // Passive frame monitor, sampling on the falling HCLK edge.
  always @(negedge HCLK) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!HRESETn) begin
        cur[k] = '{default: 0};
        prev_clk[k] = 0; prev_dt[k] = 0; prev_busy[k] = 0; prev_pen[k] = 0;
        hrun[k] = 0;
      end else begin
        if (busy[k] && !prev_busy[k]) begin
          cur[k] = '{default: 0};
          cur[k].start = cyc;
        end
        if (busy[k]) cur[k].blen++;
        if (seg_clk[k]) hrun[k]++;
        if (seg_clk[k] && !prev_clk[k]) begin
          cur[k].data = {cur[k].data[62:0], seg_dt[k]};
          cur[k].bits++;
          if (seg_dt[k] !== prev_dt[k]) viol[k]++;
        end
        if (seg_clk[k] && prev_clk[k] && seg_dt[k] !== prev_dt[k]) viol[k]++;
        if (!seg_clk[k] && prev_clk[k]) begin
          if (hrun[k] != div_of(k)) viol[k]++;
          hrun[k] = 0;
        end
        if (seg_pen[k]) begin
          cur[k].plen++;
          if (!prev_pen[k]) cur[k].ppulses++;
          if (seg_clk[k] || !busy[k]) viol[k]++;
        end
        if (seg_clk[k] && !busy[k]) viol[k]++;
        if (!busy[k] && prev_busy[k]) begin
          cur[k].fin = cyc;
          if (k == 0) q0.push_back(cur[k]); else q1.push_back(cur[k]);
        end
        prev_clk[k] = seg_clk[k]; prev_dt[k] = seg_dt[k];
        prev_busy[k] = busy[k]; prev_pen[k] = seg_pen[k];
      end
    end
  end

  function automatic fr_t pop(input int k);
    fr_t f;
    f = '{default: 0};
    if (k == 0 && q0.size() > 0) f = q0.pop_front();
    if (k == 1 && q1.size() > 0) f = q1.pop_front();
    return f;
  endfunction

  task automatic wait_frames(input int n, input int budget, output bit ok);
    int c = 0;
    while ((q0.size() < n || q1.size() < n) && c < budget) begin
      @(negedge HCLK);
      c++;
    end
    ok = (q0.size() >= n && q1.size() >= n);
  endtask

  task automatic wait_bits(input int unsigned n, output bit ok);
    int c = 0;
    while (!(busy[1] && cur[1].bits >= n && cur[1].bits < 64) && c < 2000) begin
      @(negedge HCLK);
      c++;
    end
    ok = (c < 2000);
  endtask

  task automatic apply(input logic [31:0] d, input logic [7:0] e);
    @(negedge HCLK);
    DIGITS = d; DIGIT_EN = e;
    cur_d = d; cur_en = e;
  endtask

  task automatic test_reset;
    bit ok;
    fr_t f;
    HRESETn = 1'b0; DIGITS = '0; DIGIT_EN = 8'hFF; FORCE = 1'b0;
    cur_d = '0; cur_en = 8'hFF;
    #3;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({seg_clk[k], seg_dt[k], seg_pen[k], busy[k], clr_n[k]} !== 5'b0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d got clk/dt/pen/busy/clr_n=%b exp 00000", k,
                 {seg_clk[k], seg_dt[k], seg_pen[k], busy[k], clr_n[k]});
      end
    end
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    checks++;
    if (clr_n !== 2'b11) begin
      errors++; $display("FAIL clr_n_release got %b exp 11", clr_n);
    end
    wait_frames(1, 1000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_frame_timeout got none exp frame"); end
    for (int k = 0; k < 2; k++) begin
      f = pop(k);
      checks++;
      if (f.data !== {8{8'hC0}}) begin
        errors++; $display("FAIL reset_frame_data inst%0d got %h exp %h", k, f.data, {8{8'hC0}});
      end
      checks++;
      if (f.blen != 1 + 129 * div_of(k) || f.bits != 64) begin
        errors++;
        $display("FAIL reset_frame_len inst%0d got busy=%0d bits=%0d exp busy=%0d bits=64",
                 k, f.blen, f.bits, 1 + 129 * div_of(k));
      end
      checks++;
      if (f.ppulses != 1 || f.plen != div_of(k)) begin
        errors++;
        $display("FAIL reset_frame_pen inst%0d got pulses=%0d len=%0d exp 1/%0d",
                 k, f.ppulses, f.plen, div_of(k));
      end
    end
  endtask

  task automatic test_patterns;
    logic [31:0] d [8];
    logic [7:0]  e [8];
    bit ok;
    fr_t f;
    d[0] = 32'h01234567; e[0] = 8'hFF;
    d[1] = 32'hFFFFFFFF; e[1] = 8'h0F;
    for (int i = 2; i < 8; i++) begin
      d[i] = $urandom;
      e[i] = 8'($urandom_range(0, 255));
    end
    for (int i = 0; i < 8; i++) begin
      if ({d[i], e[i]} == {cur_d, cur_en}) d[i][0] = ~d[i][0];
      apply(d[i], e[i]);
      wait_frames(1, 1000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL pattern%0d_timeout got none exp frame", i); end
      for (int k = 0; k < 2; k++) begin
        f = pop(k);
        checks++;
        if (f.data !== exp_frame(d[i], e[i]) || f.blen != 1 + 129 * div_of(k)) begin
          errors++;
          $display("FAIL pattern%0d inst%0d got %h busy=%0d exp %h busy=%0d", i, k,
                   f.data, f.blen, exp_frame(d[i], e[i]), 1 + 129 * div_of(k));
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] da, db;
    bit ok;
    fr_t f1, f2;
    da = cur_d ^ 32'h5A5A5A5A;
    db = da ^ 32'h0F0F00F0;
    apply(da, 8'hFF);
    wait_bits(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_bit20_timeout got none exp bit 20"); end
    apply(db, 8'hFF);
    wait_frames(2, 2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_timeout got fewer exp 2 frames"); end
    for (int k = 0; k < 2; k++) begin
      f1 = pop(k);
      f2 = pop(k);
      checks++;
      if (f1.data !== exp_frame(da, 8'hFF)) begin
        errors++; $display("FAIL b2b_old inst%0d got %h exp %h", k, f1.data, exp_frame(da, 8'hFF));
      end
      checks++;
      if (f2.data !== exp_frame(db, 8'hFF)) begin
        errors++; $display("FAIL b2b_new inst%0d got %h exp %h", k, f2.data, exp_frame(db, 8'hFF));
      end
      checks++;
      if (f2.start != f1.fin + 1) begin
        errors++; $display("FAIL b2b_gap inst%0d got start=%0d exp %0d", k, f2.start, f1.fin + 1);
      end
    end
  endtask

  task automatic test_force;
    bit ok;
    fr_t f;
    @(negedge HCLK); FORCE = 1'b1;
    @(negedge HCLK); FORCE = 1'b0;
    wait_bits(10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL force_idle_timeout got none exp frame"); end
    @(negedge HCLK); FORCE = 1'b1;
    @(negedge HCLK); FORCE = 1'b0;
    wait_frames(1, 1000, ok);
    for (int k = 0; k < 2; k++) begin
      f = pop(k);
      checks++;
      if (f.data !== exp_frame(cur_d, cur_en)) begin
        errors++;
        $display("FAIL force_retx inst%0d got %h exp %h", k, f.data, exp_frame(cur_d, cur_en));
      end
    end
    repeat (40) @(negedge HCLK);
    checks++;
    if (q0.size() != 0 || q1.size() != 0 || busy !== 2'b00) begin
      errors++;
      $display("FAIL force_busy_ignored got frames=%0d/%0d busy=%b exp 0/0 busy=00",
               q0.size(), q1.size(), busy);
    end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] dc;
    bit ok;
    fr_t f;
    dc = cur_d ^ 32'hC3C3C3C3;
    apply(dc, 8'hF3);
    wait_bits(30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_mid_bit30_timeout got none exp bit 30"); end
    #2 HRESETn = 1'b0;
    #1;
    checks++;
    if ({seg_clk, seg_dt, seg_pen, busy, clr_n} !== 10'b0) begin
      errors++;
      $display("FAIL rst_mid_async got clk=%b dt=%b pen=%b busy=%b clr_n=%b exp all 0",
               seg_clk, seg_dt, seg_pen, busy, clr_n);
    end
    repeat (2) @(negedge HCLK);
    q0.delete(); q1.delete();
    HRESETn = 1'b1;
    wait_frames(1, 1000, ok);
    for (int k = 0; k < 2; k++) begin
      f = pop(k);
      checks++;
      if (f.data !== exp_frame(dc, 8'hF3) || f.blen != 1 + 129 * div_of(k)) begin
        errors++;
        $display("FAIL rst_mid_refresh inst%0d got %h busy=%0d exp %h busy=%0d", k, f.data,
                 f.blen, exp_frame(dc, 8'hF3), 1 + 129 * div_of(k));
      end
    end
  endtask

  // Inputs equal to the reset snapshot: only the sent-flag can start a frame.
  task automatic test_sent_flag;
    bit ok;
    fr_t f;
    apply('0, 8'h00);
    wait_frames(1, 1000, ok);
    void'(pop(0)); void'(pop(1));
    @(negedge HCLK); HRESETn = 1'b0;
    repeat (2) @(negedge HCLK);
    q0.delete(); q1.delete();
    HRESETn = 1'b1;
    wait_frames(1, 1000, ok);
    for (int k = 0; k < 2; k++) begin
      f = pop(k);
      checks++;
      if (f.data !== {64{1'b1}} || f.bits != 64) begin
        errors++;
        $display("FAIL sent_flag inst%0d got %h bits=%0d exp %h bits=64", k, f.data, f.bits, {64{1'b1}});
      end
    end
  endtask

  task automatic test_protocol;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (viol[k] != 0) begin
        errors++; $display("FAIL protocol inst%0d got %0d violations exp 0", k, viol[k]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_patterns;
    test_back_to_back;
    test_force;
    test_reset_midframe;
    test_sent_flag;
    test_protocol;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mfp_seg7_serial_ctrl.md
MFP_SEG7_SERIAL_CTRL -- requirements
Module: mfp_seg7_serial_ctrl

Interface
REQ-001 The block SHALL have parameter DIV, default 4, meaning HCLK cycles per SEG_CLK half-period (legal range 1..255).
REQ-002 The block SHALL have port HCLK, input, 1 bit: clock, with all logic on the rising edge.
REQ-003 The block SHALL have port HRESETn, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port DIGITS, input, 32 bits: eight hex digits; digit i is DIGITS[4i+3:4i].
REQ-005 The block SHALL have port DIGIT_EN, input, 8 bits: bit i high means digit i is lit.
REQ-006 The block SHALL have port FORCE, input, 1 bit: single-cycle request to retransmit the current frame.
REQ-007 The block SHALL have port SEG_CLK, output, 1 bit: shift clock to the external display shift register.
REQ-008 The block SHALL have port SEG_DT, output, 1 bit: serial data, sampled externally on the SEG_CLK rising edge.
REQ-009 The block SHALL have port SEG_PEN, output, 1 bit: latch/output-enable strobe.
REQ-010 The block SHALL have port SEG_CLR_N, output, 1 bit: active-low clear to the shift register.
REQ-011 The block SHALL have port BUSY, output, 1 bit: frame transfer in progress.

Function
REQ-012 The block SHALL implement states IDLE, LOAD, SHIFT and LATCH.
REQ-013 In IDLE, the block SHALL move to LOAD on the next edge if {DIGITS,DIGIT_EN} differs from the last-sent snapshot, if no frame has been sent since reset, or if FORCE=1.
REQ-014 On entry to LOAD, the block SHALL capture {DIGITS,DIGIT_EN} into the snapshot; input changes after capture SHALL NOT affect the frame in flight.
REQ-015 In LOAD (1 cycle), the block SHALL build a 64-bit frame of eight bytes (digit 7 first), each byte MSB-first as {dp,g,f,e,d,c,b,a}, active-low, with dp always 1.
REQ-016 The hex-to-byte encoding SHALL be 0-F = C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.
REQ-017 A digit with DIGIT_EN[i]=0 SHALL encode as FF.
REQ-018 Each of the 64 bits in SHIFT SHALL take 2*DIV cycles: SEG_CLK low for DIV cycles with SEG_DT stable, then SEG_CLK high for DIV cycles.
REQ-019 SEG_DT SHALL change only while SEG_CLK is low.
REQ-020 After the 64th high phase, the block SHALL enter LATCH with SEG_CLK=0 and SEG_PEN=1 for DIV cycles, then return to IDLE with SEG_PEN=0.
REQ-021 BUSY SHALL be 1 in LOAD, SHIFT and LATCH, for exactly 1+129*DIV cycles per frame, and 0 in IDLE.
REQ-022 FORCE asserted while BUSY=1 SHALL be ignored (not queued).
REQ-023 A snapshot change during a frame SHALL be picked up by the IDLE comparison and trigger a new frame 1 cycle after BUSY falls.
REQ-024 The bit counter SHALL be 6-bit, and the frame SHALL end exactly at bit 63, with no wrap into a 65th bit.

Reset
REQ-025 While HRESETn=0, the outputs SHALL be SEG_CLK=0, SEG_DT=0, SEG_PEN=0, BUSY=0, SEG_CLR_N=0, with the state in IDLE and the sent-flag cleared.
REQ-026 SEG_CLR_N SHALL rise on the first HCLK edge after reset release.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately.
REQ-028 After reset release, a full frame SHALL be sent unconditionally (REQ-013).

Verification
REQ-029 Reset release with DIGITS=0, DIGIT_EN=FF, DIV=1 SHALL produce BUSY for 130 cycles, eight C0 bytes captured on SEG_CLK rising edges, and one SEG_PEN pulse.
REQ-030 DIGITS=0x01234567, DIGIT_EN=FF SHALL produce the bytes C0 F9 A4 B0 99 92 82 F8 in order.
REQ-031 DIGITS=0xFFFFFFFF, DIGIT_EN=0x0F SHALL produce the bytes FF FF FF FF 8E 8E 8E 8E.
REQ-032 Changing DIGITS at bit 20 of a frame SHALL leave that frame as the old value, after which a second frame with the new value SHALL start 1 cycle after BUSY falls.
REQ-033 A FORCE pulse in IDLE with unchanged inputs SHALL retransmit the identical frame, and a FORCE pulse while BUSY SHALL produce no extra frame.
REQ-034 Reset at bit 30 SHALL drive all outputs to their reset values asynchronously, and a full frame SHALL follow release.
